i2s_src_arbiter: RTL and testbench

Schedules and shares the I2S transmit datapath between two independent audio sources, A and B, sitting directly in front of the i2s TX sample inputs. Each source delivers stereo sample pairs over a valid/ready handshake into a one-entry holding buffer. On every I2S frame strobe the block selects, mixes or mutes the buffered samples according to a frame-aligned mode. It drains the unused source and counts underruns per source.

---
 rtl/i2s_src_arbiter.sv | 179 +++++++++++++++++
 tb/tb_i2s_src_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_src_arbiter.sv
// i2s_src_arbiter: shares the I2S TX sample inputs between two stereo sources.
// Each source fills a one-entry buffer over valid/ready. On each frame strobe
// the buffers are snapshotted and drained. One cycle later the selected, mixed
// or muted pair is registered onto the outputs, and underruns are counted.
//
// Handshake: a source transfer happens on a rising edge where valid && ready.
// ready is !full and depends on nothing else. Data is held while full.
module i2s_src_arbiter #(
  parameter int DATA_BIT = 24,
  parameter int CNT_BIT  = 16
) (
  input  logic                i_clk_12_288,
  input  logic                i_reset_n,
  input  logic                i_frame,
  input  logic [1:0]          i_mode,
  input  logic                i_clr_cnt,
  input  logic                i_a_valid,
  output logic                o_a_ready,
  input  logic [DATA_BIT-1:0] i_a_l,
  input  logic [DATA_BIT-1:0] i_a_r,
  input  logic                i_b_valid,
  output logic                o_b_ready,
  input  logic [DATA_BIT-1:0] i_b_l,
  input  logic [DATA_BIT-1:0] i_b_r,
  output logic [DATA_BIT-1:0] o_audio_l,
  output logic [DATA_BIT-1:0] o_audio_r,
  output logic                o_update,
  output logic                o_underrun,
  output logic [CNT_BIT-1:0]  o_urun_cnt_a,
  output logic [CNT_BIT-1:0]  o_urun_cnt_b
);

  localparam logic [1:0] MODE_A    = 2'b00;
  localparam logic [1:0] MODE_B    = 2'b01;
  localparam logic [1:0] MODE_MIX  = 2'b10;
  localparam logic [1:0] MODE_MUTE = 2'b11;

  localparam logic [DATA_BIT-1:0] SMAX = {1'b0, {(DATA_BIT-1){1'b1}}};
  localparam logic [DATA_BIT-1:0] SMIN = {1'b1, {(DATA_BIT-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, APPLY = 1'b1} state_t;

  state_t state, state_nxt;

  logic                a_full, b_full;
  logic [DATA_BIT-1:0] a_l, a_r, b_l, b_r;
  logic                sa_full, sb_full;
  logic [DATA_BIT-1:0] sa_l, sa_r, sb_l, sb_r;
  logic [1:0]          mode_q;
  logic                frame_take;
  logic [DATA_BIT-1:0] nxt_l, nxt_r;
  logic                urun_a, urun_b;

  // Signed add in one extra bit, clamped to the representable range.
  function automatic logic [DATA_BIT-1:0] sat_add(input logic [DATA_BIT-1:0] x,
                                                  input logic [DATA_BIT-1:0] y);
    logic [DATA_BIT:0] s;
    s = {x[DATA_BIT-1], x} + {y[DATA_BIT-1], y};
    if (s[DATA_BIT] != s[DATA_BIT-1]) return s[DATA_BIT] ? SMIN : SMAX;
    return s[DATA_BIT-1:0];
  endfunction

  assign frame_take = i_frame && (state == IDLE);
  assign o_a_ready  = !a_full;
  assign o_b_ready  = !b_full;

  // Frame FSM: IDLE waits for a strobe, APPLY lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_frame) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk_12_288) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Source buffers: a full entry is drained at a taken frame; an empty one
  // accepts, including in the frame cycle, where the new pair waits for the next frame.
  always_ff @(posedge i_clk_12_288) begin
    if (!i_reset_n) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_l <= '0; a_r <= '0; b_l <= '0; b_r <= '0;
    end else begin
      if (a_full) begin
        if (frame_take) a_full <= 1'b0;
      end else if (i_a_valid) begin
        a_full <= 1'b1;
        a_l    <= i_a_l;
        a_r    <= i_a_r;
      end
      if (b_full) begin
        if (frame_take) b_full <= 1'b0;
      end else if (i_b_valid) begin
        b_full <= 1'b1;
        b_l    <= i_b_l;
        b_r    <= i_b_r;
      end
    end
  end

  // Snapshot of mode, buffer flags and data taken at the frame strobe.
  always_ff @(posedge i_clk_12_288) begin
    if (!i_reset_n) begin
      mode_q  <= MODE_MUTE;
      sa_full <= 1'b0;
      sb_full <= 1'b0;
      sa_l <= '0; sa_r <= '0; sb_l <= '0; sb_r <= '0;
    end else if (frame_take) begin
      mode_q  <= i_mode;
      sa_full <= a_full;
      sb_full <= b_full;
      sa_l <= a_l; sa_r <= a_r; sb_l <= b_l; sb_r <= b_r;
    end
  end

  // Select/mix the snapshot; an empty source contributes zero.
  always_comb begin
    nxt_l  = '0;
    nxt_r  = '0;
    urun_a = 1'b0;
    urun_b = 1'b0;
    case (mode_q)
      MODE_A: begin
        if (sa_full) begin nxt_l = sa_l; nxt_r = sa_r; end
        urun_a = !sa_full;
      end
      MODE_B: begin
        if (sb_full) begin nxt_l = sb_l; nxt_r = sb_r; end
        urun_b = !sb_full;
      end
      MODE_MIX: begin
        nxt_l  = sat_add(sa_full ? sa_l : '0, sb_full ? sb_l : '0);
        nxt_r  = sat_add(sa_full ? sa_r : '0, sb_full ? sb_r : '0);
        urun_a = !sa_full;
        urun_b = !sb_full;
      end
      default: ;
    endcase
  end

  // Output registers: loaded in APPLY, pulses last one cycle.
  always_ff @(posedge i_clk_12_288) begin
    if (!i_reset_n) begin
      o_audio_l  <= '0;
      o_audio_r  <= '0;
      o_update   <= 1'b0;
      o_underrun <= 1'b0;
    end else if (state == APPLY) begin
      o_audio_l  <= nxt_l;
      o_audio_r  <= nxt_r;
      o_update   <= 1'b1;
      o_underrun <= urun_a || urun_b;
    end else begin
      o_update   <= 1'b0;
      o_underrun <= 1'b0;
    end
  end

  // Saturating underrun counters; clear has priority over an increment.
  always_ff @(posedge i_clk_12_288) begin
    if (!i_reset_n || i_clr_cnt) begin
      o_urun_cnt_a <= '0;
      o_urun_cnt_b <= '0;
    end else if (state == APPLY) begin
      if (urun_a && (o_urun_cnt_a != {CNT_BIT{1'b1}}))
        o_urun_cnt_a <= o_urun_cnt_a + CNT_BIT'(1);
      if (urun_b && (o_urun_cnt_b != {CNT_BIT{1'b1}}))
        o_urun_cnt_b <= o_urun_cnt_b + CNT_BIT'(1);
    end
  end

endmodule

// File: tb/tb_i2s_src_arbiter.sv
// Directed bench for i2s_src_arbiter: one task per scenario, inline checks.
// The counter width is reduced so saturation is reachable in a short run.
module tb_i2s_src_arbiter;

  localparam int DW = 24;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          frame;
  logic [1:0]    mode;
  logic          clr_cnt;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [DW-1:0] a_l, a_r, b_l, b_r;
  logic [DW-1:0] audio_l, audio_r;
  logic          update, underrun;
  logic [CW-1:0] cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;
  int acc_a = 0;

  i2s_src_arbiter #(.DATA_BIT(DW), .CNT_BIT(CW)) dut (
    .i_clk_12_288(clk),
    .i_reset_n(rst_n),
    .i_frame(frame),
    .i_mode(mode),
    .i_clr_cnt(clr_cnt),
    .i_a_valid(a_valid),
    .o_a_ready(a_ready),
    .i_a_l(a_l),
    .i_a_r(a_r),
    .i_b_valid(b_valid),
    .o_b_ready(b_ready),
    .i_b_l(b_l),
    .i_b_r(b_r),
    .o_audio_l(audio_l),
    .o_audio_r(audio_r),
    .o_update(update),
    .o_underrun(underrun),
    .o_urun_cnt_a(cnt_a),
    .o_urun_cnt_b(cnt_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source A transfer counter, sampled mid-cycle before the accepting edge.
  always @(negedge clk) if (a_valid && a_ready) acc_a++;

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic send_a(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int wait_n;
    wait_n = 0;
    while (!a_ready && wait_n < 10) begin @(posedge clk); #1; wait_n++; end
    total++;
    if (!a_ready) begin bad++; $display("FAIL send_a_timeout ready=%0b want=1", a_ready); end
    a_valid = 1'b1; a_l = l; a_r = r;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int wait_n;
    wait_n = 0;
    while (!b_ready && wait_n < 10) begin @(posedge clk); #1; wait_n++; end
    total++;
    if (!b_ready) begin bad++; $display("FAIL send_b_timeout ready=%0b want=1", b_ready); end
    b_valid = 1'b1; b_l = l; b_r = r;
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  // Strobe a frame, then capture outputs two cycles after the strobe cycle.
  task automatic run_frame(input logic [1:0] m, output logic [DW-1:0] l,
                           output logic [DW-1:0] r, output logic upd, output logic ur);
    frame = 1'b1; mode = m;
    @(posedge clk); #1;
    frame = 1'b0;
    @(posedge clk); #1;
    l = audio_l; r = audio_r; upd = update; ur = underrun;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin bad++;
      $display("FAIL reset_ready a=%0b b=%0b want=1", a_ready, b_ready); end
    total++; if (audio_l !== '0 || audio_r !== '0) begin bad++;
      $display("FAIL reset_audio l=%h r=%h want=0", audio_l, audio_r); end
    total++; if (update !== 1'b0 || underrun !== 1'b0) begin bad++;
      $display("FAIL reset_pulses upd=%0b ur=%0b want=0", update, underrun); end
    total++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin bad++;
      $display("FAIL reset_cnt a=%0d b=%0d want=0", cnt_a, cnt_b); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_underrun_empty;
    logic [DW-1:0] l, r; logic upd, ur;
    run_frame(2'b00, l, r, upd, ur);
    total++; if (l !== '0 || r !== '0) begin bad++;
      $display("FAIL empty_audio l=%h r=%h want=0", l, r); end
    total++; if (upd !== 1'b1 || ur !== 1'b1) begin bad++;
      $display("FAIL empty_pulses upd=%0b ur=%0b want=1", upd, ur); end
    total++; if (cnt_a !== 8'd1 || cnt_b !== 8'd0) begin bad++;
      $display("FAIL empty_cnt a=%0d b=%0d want 1/0", cnt_a, cnt_b); end
    idle(1);
    total++; if (update !== 1'b0 || underrun !== 1'b0) begin bad++;
      $display("FAIL empty_pulse_len upd=%0b ur=%0b want=0", update, underrun); end
    idle(3);
  endtask

  task automatic test_select_a;
    logic [DW-1:0] l, r; logic upd, ur;
    send_a(24'h000123, 24'h7FFFFF);
    send_b(24'h000555, 24'h000555);
    total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++;
      $display("FAIL sel_full a=%0b b=%0b want=0", a_ready, b_ready); end
    run_frame(2'b00, l, r, upd, ur);
    total++; if (l !== 24'h000123 || r !== 24'h7FFFFF) begin bad++;
      $display("FAIL sel_a_audio l=%h r=%h want 000123/7fffff", l, r); end
    total++; if (upd !== 1'b1 || ur !== 1'b0) begin bad++;
      $display("FAIL sel_a_pulses upd=%0b ur=%0b want 1/0", upd, ur); end
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin bad++;
      $display("FAIL sel_drain a=%0b b=%0b want=1", a_ready, b_ready); end
    total++; if (cnt_a !== 8'd1 || cnt_b !== 8'd0) begin bad++;
      $display("FAIL sel_cnt a=%0d b=%0d want 1/0", cnt_a, cnt_b); end
    idle(3);
  endtask

  task automatic test_mix;
    logic [DW-1:0] l, r; logic upd, ur;
    send_a(24'h700000, 24'h900000);
    send_b(24'h200000, 24'h900000);
    run_frame(2'b10, l, r, upd, ur);
    total++; if (l !== 24'h7FFFFF || r !== 24'h800000) begin bad++;
      $display("FAIL mix_sat l=%h r=%h want 7fffff/800000", l, r); end
    total++; if (ur !== 1'b0) begin bad++;
      $display("FAIL mix_sat_ur ur=%0b want=0", ur); end
    idle(3);
    send_a(24'h000010, 24'h000005);
    send_b(24'hFFFFF0, 24'h000003);
    run_frame(2'b10, l, r, upd, ur);
    total++; if (l !== 24'h000000 || r !== 24'h000008) begin bad++;
      $display("FAIL mix_plain l=%h r=%h want 000000/000008", l, r); end
    idle(3);
    send_a(24'h000100, 24'hFFFFFF);
    run_frame(2'b10, l, r, upd, ur);
    total++; if (l !== 24'h000100 || r !== 24'hFFFFFF) begin bad++;
      $display("FAIL mix_one l=%h r=%h want 000100/ffffff", l, r); end
    total++; if (ur !== 1'b1) begin bad++;
      $display("FAIL mix_one_ur ur=%0b want=1", ur); end
    total++; if (cnt_a !== 8'd1 || cnt_b !== 8'd1) begin bad++;
      $display("FAIL mix_one_cnt a=%0d b=%0d want 1/1", cnt_a, cnt_b); end
    idle(3);
  endtask

  task automatic test_frame_collision;
    logic [DW-1:0] l, r; logic upd, ur;
    frame = 1'b1; mode = 2'b00;
    a_valid = 1'b1; a_l = 24'h0ABCDE; a_r = 24'h012345;
    @(posedge clk); #1;
    frame = 1'b0; a_valid = 1'b0;
    total++; if (a_ready !== 1'b0) begin bad++;
      $display("FAIL coll_stored ready=%0b want=0", a_ready); end
    @(posedge clk); #1;
    total++; if (underrun !== 1'b1 || audio_l !== '0) begin bad++;
      $display("FAIL coll_urun ur=%0b l=%h want 1/0", underrun, audio_l); end
    total++; if (cnt_a !== 8'd2) begin bad++;
      $display("FAIL coll_cnt a=%0d want=2", cnt_a); end
    idle(3);
    run_frame(2'b00, l, r, upd, ur);
    total++; if (l !== 24'h0ABCDE || r !== 24'h012345 || ur !== 1'b0) begin bad++;
      $display("FAIL coll_next l=%h r=%h ur=%0b want 0abcde/012345/0", l, r, ur); end
    idle(3);
  endtask

  task automatic test_mute;
    logic [DW-1:0] l, r; logic upd, ur;
    int upd_n;
    upd_n = 0;
    acc_a = 0;
    a_valid = 1'b1; a_l = 24'h111111; a_r = 24'h222222;
    idle(3);
    for (int f = 0; f < 3; f++) begin
      run_frame(2'b11, l, r, upd, ur);
      if (upd) upd_n++;
      total++; if (l !== '0 || r !== '0 || ur !== 1'b0) begin bad++;
        $display("FAIL mute_out f=%0d l=%h r=%h ur=%0b want 0/0/0", f, l, r, ur); end
      idle(4);
    end
    a_valid = 1'b0;
    total++; if (upd_n !== 3) begin bad++;
      $display("FAIL mute_updates got=%0d want=3", upd_n); end
    total++; if (acc_a !== 4) begin bad++;
      $display("FAIL mute_accepts got=%0d want=4", acc_a); end
    total++; if (cnt_a !== 8'd2 || cnt_b !== 8'd1) begin bad++;
      $display("FAIL mute_cnt a=%0d b=%0d want 2/1", cnt_a, cnt_b); end
    run_frame(2'b11, l, r, upd, ur);
    idle(3);
  endtask

  task automatic test_mode_midframe;
    logic [DW-1:0] l, r; logic upd, ur;
    send_a(24'h000AAA, 24'h000BBB);
    frame = 1'b1; mode = 2'b00;
    @(posedge clk); #1;
    frame = 1'b0; mode = 2'b01;
    @(posedge clk); #1;
    total++; if (audio_l !== 24'h000AAA || audio_r !== 24'h000BBB || underrun !== 1'b0) begin bad++;
      $display("FAIL midmode_out l=%h r=%h ur=%0b want 000aaa/000bbb/0", audio_l, audio_r, underrun); end
    idle(4);
    total++; if (audio_l !== 24'h000AAA) begin bad++;
      $display("FAIL midmode_hold l=%h want 000aaa", audio_l); end
    run_frame(2'b01, l, r, upd, ur);
    total++; if (l !== '0 || ur !== 1'b1 || cnt_b !== 8'd2 || cnt_a !== 8'd2) begin bad++;
      $display("FAIL midmode_next l=%h ur=%0b a=%0d b=%0d want 0/1/2/2", l, ur, cnt_a, cnt_b); end
    idle(3);
  endtask

  task automatic test_saturation;
    logic [DW-1:0] l, r; logic upd, ur;
    int exp_a;
    exp_a = 2;
    for (int i = 0; i < 260; i++) begin
      run_frame(2'b00, l, r, upd, ur);
      if (exp_a < 255) exp_a++;
    end
    total++; if (cnt_a !== exp_a[CW-1:0] || cnt_a !== 8'hFF) begin bad++;
      $display("FAIL sat_cnt a=%h want=ff", cnt_a); end
    total++; if (cnt_b !== 8'd2) begin bad++;
      $display("FAIL sat_cnt_b b=%0d want=2", cnt_b); end
    // Clear coincident with an increment in APPLY.
    frame = 1'b1; mode = 2'b10;
    @(posedge clk); #1;
    frame = 1'b0; clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    total++; if (underrun !== 1'b1 || cnt_a !== 8'd0 || cnt_b !== 8'd0) begin bad++;
      $display("FAIL clr_wins ur=%0b a=%0d b=%0d want 1/0/0", underrun, cnt_a, cnt_b); end
    idle(3);
  endtask

  task automatic test_reset_mid_apply;
    logic [DW-1:0] l, r; logic upd, ur;
    frame = 1'b1; mode = 2'b10;
    a_valid = 1'b1; a_l = 24'h123456; a_r = 24'h654321;
    b_valid = 1'b1; b_l = 24'h000001; b_r = 24'h000002;
    @(posedge clk); #1;
    frame = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin bad++;
      $display("FAIL rst_apply_ready a=%0b b=%0b want=1", a_ready, b_ready); end
    total++; if (update !== 1'b0 || underrun !== 1'b0 || audio_l !== '0 || audio_r !== '0) begin bad++;
      $display("FAIL rst_apply_out upd=%0b ur=%0b l=%h r=%h want 0", update, underrun, audio_l, audio_r); end
    rst_n = 1'b1;
    idle(2);
    run_frame(2'b00, l, r, upd, ur);
    total++; if (l !== '0 || ur !== 1'b1 || cnt_a !== 8'd1) begin bad++;
      $display("FAIL rst_discard l=%h ur=%0b a=%0d want 0/1/1", l, ur, cnt_a); end
    idle(3);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; frame = 1'b0; mode = 2'b00; clr_cnt = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_l = '0; a_r = '0; b_l = '0; b_r = '0;
    #1;
    test_reset();
    test_underrun_empty();
    test_select_a();
    test_mix();
    test_frame_collision();
    test_mute();
    test_mode_midframe();
    test_saturation();
    test_reset_mid_apply();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
